// File: rtl/avalon_wait_ram.sv
`default_nettype none
// ============================================================================
// Module   : avalon_wait_ram
// Purpose  : Avalon-MM word RAM with fixed (or LFSR-random) waitrequest
//            stalls plus an always-on preload port. Optional feature macro:
//            AVALON_WAIT_RAM_RANDOM_WAIT_EN (random 1..4 cycle waits).
// Revision : 1.0 - initial release
// ============================================================================
module avalon_wait_ram #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [3:0]          w_cnt_load;
  logic                r_is_wr;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_req;
  logic                w_rd_cap;
  logic                w_wr_commit;
  logic [ADDR_W-1:0]   w_idx_in;
  logic [ADDR_W-1:0]   w_load_idx;
  logic [ADDR_W-1:0]   w_rd_idx;
  logic                w_unused;

  assign w_req      = read | write;
  assign w_idx_in   = address[ADDR_W+1:2];
  assign w_load_idx = load_addr[ADDR_W+1:2];
  assign w_rd_idx   = (r_state == S_IDLE) ? w_idx_in : r_idx;
  assign w_unused   = ^{address[31:ADDR_W+2], address[1:0],
                        load_addr[31:ADDR_W+2], load_addr[1:0]};

`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
  logic [3:0] r_lfsr;

  // x^4 + x^3 + 1 Fibonacci LFSR; load value is wait-1, so 0..3 -> 1..4 cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 4'b1001;
    end else begin
      r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end
  end

  assign w_cnt_load = {2'b00, r_lfsr[1:0]};
`else
  assign w_cnt_load = c_WAIT_LOAD;
`endif

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    waitrequest = 1'b0;
    w_rd_cap    = 1'b0;
    w_wr_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          waitrequest = 1'b1;
          w_cnt_next  = w_cnt_load;
          if (w_cnt_load == 4'd0) begin
            w_next   = S_ACK;
            w_rd_cap = ~write;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        waitrequest = 1'b1;
        if (!w_req) begin
          // master withdrew the command: abandon with no side effects
          w_next     = S_IDLE;
          w_cnt_next = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_next     = S_ACK;
          w_cnt_next = 4'd0;
          w_rd_cap   = ~r_is_wr;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_ACK: begin
        w_next      = S_IDLE;
        w_wr_commit = r_is_wr;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_is_wr  <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
      readdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req) begin
        r_is_wr <= write;
        r_idx   <= w_idx_in;
        r_wdata <= writedata;
        r_be    <= byteenable;
      end
      if (w_rd_cap) begin
        readdata <= r_mem[w_rd_idx];
      end
    end
  end

  // Memory is never reset; the later preload assignment wins a same-word clash
  always_ff @(posedge clk) begin
    if (w_wr_commit && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
    if (load_en) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_wait_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_wait_ram
// Purpose  : Directed self-checking bench; dut1 uses WAIT_CYCLES=1, dut3 uses 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_wait_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = 4'hF;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        read1, write1, read3, write3;
  logic        wait1, wait3, waitrequest;
  logic [31:0] rdata1, rdata3, readdata;

  int n_checks = 0;
  int n_errors = 0;

  assign read1       = rd & ~sel;
  assign write1      = wr & ~sel;
  assign read3       = rd & sel;
  assign write3      = wr & sel;
  assign waitrequest = sel ? wait3 : wait1;
  assign readdata    = sel ? rdata3 : rdata1;

  always #5 clk = ~clk;

  avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .read(read1), .write(write1),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wait1),
    .readdata(rdata1), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .address(address), .read(read3), .write(write3),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wait3),
    .readdata(rdata3), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_wait(input string tag, input int n, input int exp);
`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
    check_eq(tag, 32'(n >= 1 && n <= 4), 32'd1);
`else
    check_eq(tag, 32'(n), 32'(exp));
`endif
  endtask

  // Starts and ends at posedge+1; keep leaves the command asserted
  task automatic bus_xfer(input logic is_rd, input logic is_wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic keep,
                          input logic coload, input logic [31:0] cdata,
                          output int nwait, output logic [31:0] rdat);
    logic done;
    rd = is_rd; wr = is_wr; address = addr; writedata = wdata; byteenable = be;
    nwait = 0; done = 1'b0; rdat = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (waitrequest) nwait++;
      else done = 1'b1;
    end
    if (!done) check_eq("timeout", 32'd0, 32'd1);
    rdat = readdata;
    if (coload) begin
      load_en = 1'b1; load_addr = addr; load_data = cdata;
    end
    @(posedge clk); #1;
    load_en = 1'b0;
    if (!keep) begin
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int          nw;
  logic [31:0] rv;
  logic [7:0]  pat;
  logic [31:0] rds [8];

  initial begin
    // preload during reset
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_en = 1'b1;
      load_addr = 32'h4 + 32'(i) * 4;
      case (i)
        0: load_data = 32'h24020010;
        1: load_data = 32'h11223344;
        2: load_data = 32'h00000000;
        3: load_data = 32'h00000055;
        default: load_data = 32'h00000077;
      endcase
      @(posedge clk); #1;
    end
    load_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_rdata1", rdata1, 32'h0);
    check_eq("rst_rdata3", rdata3, 32'h0);
    check_eq("rst_wait1", {31'd0, wait1}, 32'h0);
    check_eq("rst_wait3", {31'd0, wait3}, 32'h0);
    @(posedge clk); #1;

    sel = 1'b0;
    bus_xfer(1, 0, 32'h04, 0, 4'hF, 0, 0, 0, nw, rv);
    check_wait("rd04_wait", nw, 1);
    check_eq("rd04_data", rv, 32'h24020010);

    bus_xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'b0101, 0, 0, 0, nw, rv);
    check_wait("wr08_wait", nw, 1);
    check_eq("wr08_rd_hold", rv, 32'h24020010);
    bus_xfer(1, 0, 32'h08, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("rd08_be", rv, 32'h11AD33EF);

    bus_xfer(1, 0, 32'h1004, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("alias_rd", rv, 32'h24020010);
    bus_xfer(0, 1, 32'h2014, 32'hCAFE0001, 4'hF, 0, 0, 0, nw, rv);
    bus_xfer(1, 0, 32'h14, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("alias_wr", rv, 32'hCAFE0001);

    bus_xfer(1, 1, 32'h10, 32'h000000A0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("rdwr_hold", rv, 32'hCAFE0001);
    bus_xfer(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("rdwr_word", rv, 32'h000000A0);

    bus_xfer(0, 1, 32'h18, 32'h12345678, 4'hF, 0, 1, 32'hABCDEF01, nw, rv);
    bus_xfer(1, 0, 32'h18, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("load_wins", rv, 32'hABCDEF01);

    sel = 1'b1;
    bus_xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'b0101, 0, 0, 0, nw, rv);
    check_wait("wr08_wait3", nw, 3);

`ifndef AVALON_WAIT_RAM_RANDOM_WAIT_EN
    // back-to-back reads with the command held continuously
    rd = 1'b1; address = 32'h04;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[7-i] = waitrequest;
      rds[i] = readdata;
      if (i == 3) begin
        @(posedge clk); #1;
        address = 32'h08;
      end
    end
    @(posedge clk); #1;
    rd = 1'b0;
    check_eq("b2b_pattern", {24'd0, pat}, 32'h000000EE);
    check_eq("b2b_stale0", rds[2], 32'h0);
    check_eq("b2b_rd0", rds[3], 32'h24020010);
    check_eq("b2b_stale1", rds[6], 32'h24020010);
    check_eq("b2b_rd1", rds[7], 32'h11AD33EF);

    // master withdraws during WAIT
    rd = 1'b1; address = 32'h10;
    @(posedge clk); #1;
    rd = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_rd_hold", rdata3, 32'h11AD33EF);
    wr = 1'b1; address = 32'h14; writedata = 32'h5555; byteenable = 4'hF;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #1;
    bus_xfer(1, 0, 32'h14, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("abort_wr_mem", rv, 32'h00000077);
`endif

    bus_xfer(1, 0, 32'h04, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("pre_rst_rd", rv, 32'h24020010);
    wr = 1'b1; address = 32'h0C; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0;
    @(negedge clk);
    check_eq("midrst_rdata", rdata3, 32'h0);
    check_eq("midrst_idle", {31'd0, wait3}, 32'h0);
    @(posedge clk); #1;
    bus_xfer(1, 0, 32'h0C, 0, 4'hF, 0, 0, 0, nw, rv);
    check_wait("post_rst_wait", nw, 3);
    check_eq("midrst_nowrite", rv, 32'h0);
    bus_xfer(1, 0, 32'h08, 0, 4'hF, 0, 0, 0, nw, rv);
    check_eq("rst_keeps_mem", rv, 32'h11AD33EF);

`ifdef AVALON_WAIT_RAM_RANDOM_WAIT_EN
    begin
      int c0 [3];
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
        bus_xfer(1, 0, 32'h04, 0, 4'hF, 0, 0, 0, nw, rv);
        c0[i] = nw;
        check_wait("rand_range", nw, 0);
      end
      do_reset();
      for (int i = 0; i < 3; i++) begin
        bus_xfer(1, 0, 32'h04, 0, 4'hF, 0, 0, 0, nw, rv);
        check_eq("rand_repeat", 32'(nw), 32'(c0[i]));
      end
    end
`else
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avalon_wait_ram.md
AVALON_WAIT_RAM -- requirements
Module: avalon_wait_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the memory depth as 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal range 1..15, giving the fixed number of waitrequest-high cycles per transfer.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port address, input, 32 bits: Avalon byte address; the word index is address[ADDR_W+1:2]; address[1:0] and the upper bits are ignored.
REQ-006 SHALL have ports read and write, input, 1 bit each: Avalon commands from the CPU master.
REQ-007 SHALL have port writedata, input, 32 bits: write data.
REQ-008 SHALL have port byteenable, input, 4 bits: bit i enables writedata[8i+7:8i].
REQ-009 SHALL have port waitrequest, output, 1 bit: stall indication to the master.
REQ-010 SHALL have port readdata, output, 32 bits, registered: read data.
REQ-011 SHALL have ports load_en (input, 1 bit), load_addr (input, 32 bits, byte address) and load_data (input, 32 bits): the preload port that writes program words.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT and ACK.
REQ-013 In IDLE with read|write asserted, the block SHALL drive waitrequest=1 combinationally, load the wait counter with WAIT_CYCLES-1, latch the command type, and go to WAIT, or to ACK if the counter value is 0.
REQ-014 In WAIT, the block SHALL hold waitrequest=1 and decrement the counter, then go to ACK when the counter reaches 0.
REQ-015 For a read, readdata SHALL be loaded from the memory on the clock edge that enters ACK.
REQ-016 In ACK, waitrequest SHALL be 0 and readdata SHALL be valid.
REQ-017 For a write, the enabled bytes SHALL be committed on the clock edge that leaves ACK.
REQ-018 ACK SHALL always return to IDLE.
REQ-019 Per transfer, waitrequest SHALL be high for exactly WAIT_CYCLES cycles followed by one low cycle; back-to-back requests SHALL each pay the full wait.
REQ-020 In IDLE with no request, waitrequest SHALL be 0.
REQ-021 read and write asserted together SHALL be treated as a write; readdata SHALL remain unchanged.
REQ-022 If the master drops read|write while in WAIT, the FSM SHALL return to IDLE with no memory write and no readdata update.
REQ-023 load_en=1 SHALL write load_data in full to word load_addr[ADDR_W+1:2] on that clock edge, in any state, including during reset.
REQ-024 A load and a bus write committing to the same word on the same edge SHALL resolve with the load winning.
REQ-025 readdata SHALL hold its last value between reads.
REQ-026 An address beyond the depth SHALL alias modulo 2**ADDR_W words.

Reset
REQ-027 reset SHALL force IDLE, readdata=0 and waitrequest=0 (when no request is present), and SHALL clear the counter.
REQ-028 Memory contents SHALL NOT be altered by reset.
REQ-029 Reset asserted mid-transfer SHALL abort it, and a pending write SHALL NOT be committed.
REQ-030 The first transfer after reset deasserts SHALL start cleanly from IDLE.

Configuration
REQ-031 With macro AVALON_WAIT_RAM_RANDOM_WAIT_EN defined, the block SHALL include a 4-bit Fibonacci LFSR (x^4+x^3+1) that is reset to 4'b1001 and advances every clock.
REQ-032 With that macro defined, the wait count SHALL be {LFSR[1:0]}+1, giving 1..4 cycles, sampled in IDLE when a request arrives; WAIT_CYCLES SHALL be ignored.
REQ-033 Without that macro, no LFSR logic SHALL exist and the fixed WAIT_CYCLES behaviour SHALL apply.

Verification
REQ-034 Preload 0x24020010 at 0x04, then read 0x04 with WAIT_CYCLES=1 -> waitrequest is high for 1 cycle, then low with readdata=0x24020010.
REQ-035 Preload 0x11223344 at 0x08, write 0xDEADBEEF with byteenable=4'b0101, then read 0x08 -> 0x11AD33EF.
REQ-036 Set WAIT_CYCLES=3 and issue back-to-back reads of 0x04 and 0x08 -> waitrequest follows 1,1,1,0,1,1,1,0 and readdata updates only in the low cycles.
REQ-037 Assert reset during WAIT of a write of 0xFFFFFFFF to 0x0C (preloaded 0x0) -> readdata=0, FSM in IDLE, and a later read of 0x0C returns 0x0.
REQ-038 Assert read and write together at 0x10 with writedata 0x000000A0 -> the word becomes 0xA0 and readdata is unchanged.
REQ-039 With the macro defined, two identical runs after reset -> identical waitrequest-high counts, each in the range 1..4.
